// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-cache memory port arbiter.
// FSM state encoding, grant IDs and the round-robin pick helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef logic gnt_id_t;

    localparam gnt_id_t GNT_ID_I = 1'b0;
    localparam gnt_id_t GNT_ID_D = 1'b1;

    // D wins when alone, or on a conflict when I was granted last.
    function automatic gnt_id_t pick_grant(
        input logic    i_req,
        input logic    d_req,
        input gnt_id_t last
    );
        if (d_req && (!i_req || last == GNT_ID_I)) begin
            return GNT_ID_D;
        end
        return GNT_ID_I;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating grant watchdog for the memory port arbiter.
// expired flags the cycle whose edge brings the count to TIMEOUT.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && count_q != MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_d == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache.
// One transaction in flight, round-robin on conflict, sticky watchdog error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_e        state_q, state_d;
    gnt_id_t           last_q, last_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic    d_req;
    gnt_id_t gnt_pick;
    logic    wd_clear;
    logic    wd_en;
    logic    wd_expired;

    assign d_req    = d_read || d_write;
    assign gnt_pick = pick_grant(i_read, d_req, last_q);

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GNT_ID_I;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        wd_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    wd_clear = 1'b1;
                    last_d   = gnt_pick;
                    if (gnt_pick == GNT_ID_D) begin
                        // A simultaneous read and write is a write.
                        state_d = GNT_D;
                        rd_d    = d_read && !d_write;
                        wr_d    = d_write;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = GNT_I;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        addr_d  = i_addr;
                        wdata_d = '0;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (wd_expired) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // Ready is masked by rst so an abandoned grant never completes.
    always_comb begin
        i_ready = !rst && mem_ready && (state_q == GNT_I);
        d_ready = !rst && mem_ready && (state_q == GNT_D);
        wd_en   = (state_q != IDLE) && !mem_ready;
        i_rdata = mem_rdata;
        d_rdata = mem_rdata;
    end

    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Expected commands and ready pulses are queued by stimulus, popped by monitors.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic i_read;
    logic [AW-1:0] i_addr;
    logic d_read;
    logic d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_rdata;
    logic resp_ready;
    logic stray_ready;
    logic mem_ready;

    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic i_ready, d_ready, mem_read, mem_write, err;

    logic t_i_read;
    logic t_d_read;
    logic t_d_write;
    logic t_mem_ready;
    logic [DW-1:0] t_i_rdata, t_d_rdata, t_mem_wdata;
    logic [AW-1:0] t_mem_addr;
    logic t_i_ready, t_d_ready, t_mem_read, t_mem_write, t_err;

    int checks = 0;
    int failures = 0;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int resp_lat = 4;
    bit resp_en = 1'b1;
    logic [DW-1:0] resp_data;

    assign mem_ready = resp_ready | stray_ready;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    mem_port_arbiter #(.TIMEOUT(8)) dut_t (
        .clk(clk), .rst(rst),
        .i_read(t_i_read), .i_addr(i_addr),
        .i_rdata(t_i_rdata), .i_ready(t_i_ready),
        .d_read(t_d_read), .d_write(t_d_write),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(t_d_rdata), .d_ready(t_d_ready),
        .mem_read(t_mem_read), .mem_write(t_mem_write),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(t_mem_ready),
        .err(t_err)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] w);
        cmd_t c;
        c.rd = rd;
        c.wr = wr;
        c.addr = a;
        c.wdata = w;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input logic is_d, input logic [DW-1:0] dat);
        rsp_t r;
        r.is_d = is_d;
        r.data = dat;
        rsp_q.push_back(r);
    endtask

    task automatic wait_rdy(input string nm, input int sel);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            case (sel)
                0: seen = i_ready;
                1: seen = d_ready;
                default: seen = i_ready || d_ready;
            endcase
        end
        chk(nm, seen, 1'b1);
    endtask

    // Memory model: answers each command after resp_lat cycles.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        resp_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            if (resp_en && (mem_read || mem_write)) begin
                wcnt++;
                if (wcnt == resp_lat) begin
                    resp_ready = 1'b1;
                    mem_rdata = resp_data;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : ready_mon
        rsp_t e;
        forever begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_ready", {126'd0, i_ready, d_ready}, '0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("ready_src", {126'd0, i_ready, d_ready},
                        e.is_d ? 128'd1 : 128'd2);
                    chk("rdata", e.is_d ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    initial begin : cmd_mon
        cmd_t c;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((mem_read || mem_write) && !prev) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {126'd0, mem_read, mem_write}, '0);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_rd", mem_read, c.rd);
                    chk("cmd_wr", mem_write, c.wr);
                    chk("cmd_addr", mem_addr, c.addr);
                    if (c.wr) chk("cmd_wdata", mem_wdata, c.wdata);
                end
            end
            prev = mem_read || mem_write;
        end
    end

    initial begin : guard
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin : stim
        bit seen;
        rst = 1'b1;
        i_read = 1'b0;
        i_addr = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        stray_ready = 1'b1;
        resp_data = '0;
        t_i_read = 1'b0;
        t_d_read = 1'b0;
        t_d_write = 1'b0;
        t_mem_ready = 1'b0;

        // Reset state, ready masked even with mem_ready high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ready", i_ready, 1'b0);
        chk("rst_d_ready", d_ready, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_err", err, 1'b0);
        cyc();
        rst = 1'b0;

        // Stray mem_ready in IDLE
        repeat (3) begin
            @(negedge clk);
            chk("idle_i_ready", i_ready, 1'b0);
            chk("idle_d_ready", d_ready, 1'b0);
        end
        cyc();
        stray_ready = 1'b0;

        // I-only read, 10-cycle memory
        resp_lat = 10;
        resp_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_F625;
        i_addr = 28'h0000010;
        i_read = 1'b1;
        push_cmd(1'b1, 1'b0, 28'h0000010, '0);
        push_rsp(1'b0, resp_data);
        @(negedge clk);
        chk("i_cycle0_rd", mem_read, 1'b0);
        @(negedge clk);
        chk("i_cycle1_rd", mem_read, 1'b1);
        chk("i_cycle1_addr", mem_addr, 28'h0000010);
        wait_rdy("i_only_ready", 0);
        cyc();
        i_read = 1'b0;
        @(negedge clk);
        chk("i_only_drop", mem_read, 1'b0);
        chk("i_ready_pulse_end", i_ready, 1'b0);

        // Conflict right after reset: D first, one IDLE gap, then I
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        resp_lat = 3;
        resp_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        i_addr = 28'h0000020;
        i_read = 1'b1;
        d_addr = 28'h00000A0;
        d_wdata = {4{32'h6F568000}};
        d_write = 1'b1;
        push_cmd(1'b0, 1'b1, 28'h00000A0, {4{32'h6F568000}});
        push_cmd(1'b1, 1'b0, 28'h0000020, '0);
        push_rsp(1'b1, resp_data);
        push_rsp(1'b0, resp_data);
        wait_rdy("conf_d_ready", 1);
        cyc();
        d_write = 1'b0;
        @(negedge clk);
        chk("conf_gap_rd", mem_read, 1'b0);
        chk("conf_gap_wr", mem_write, 1'b0);
        @(negedge clk);
        chk("conf_i_rd", mem_read, 1'b1);
        chk("conf_i_addr", mem_addr, 28'h0000020);
        wait_rdy("conf_i_ready", 0);
        cyc();
        i_read = 1'b0;

        // Fairness: both hold requests for 6 transactions
        resp_lat = 2;
        resp_data = 128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0;
        i_addr = 28'h0000030;
        d_addr = 28'h0000040;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                push_cmd(1'b1, 1'b0, 28'h0000040, '0);
                push_rsp(1'b1, resp_data);
            end else begin
                push_cmd(1'b1, 1'b0, 28'h0000030, '0);
                push_rsp(1'b0, resp_data);
            end
        end
        for (int k = 0; k < 6; k++) begin
            wait_rdy("fair_ready", 2);
        end
        cyc();
        i_read = 1'b0;
        d_read = 1'b0;

        // Grant stability under changing D inputs
        resp_lat = 6;
        resp_data = 128'hCAFE_0000_0000_0000_0000_0000_0000_0026;
        d_addr = 28'h0000050;
        d_read = 1'b1;
        push_cmd(1'b1, 1'b0, 28'h0000050, '0);
        push_rsp(1'b1, resp_data);
        @(posedge clk);
        @(negedge clk);
        chk("stab_addr0", mem_addr, 28'h0000050);
        cyc();
        d_addr = 28'h1234567;
        d_write = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            chk("stab_addr", mem_addr, 28'h0000050);
            chk("stab_rd", mem_read, 1'b1);
            chk("stab_wr", mem_write, 1'b0);
            seen = d_ready;
        end
        chk("stab_done", seen, 1'b1);
        cyc();
        d_read = 1'b0;
        d_write = 1'b0;
        d_addr = '0;

        // Reset in the 3rd GNT_I cycle, then stray mem_ready
        resp_en = 1'b0;
        i_addr = 28'h0000060;
        i_read = 1'b1;
        push_cmd(1'b1, 1'b0, 28'h0000060, '0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_gnt_rd", mem_read, 1'b1);
        rst = 1'b1;
        i_read = 1'b0;
        stray_ready = 1'b1;
        #1;
        chk("rstmid_i_ready", i_ready, 1'b0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_rd", mem_read, 1'b0);
        chk("rstmid_err", err, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_stray", i_ready, 1'b0);
        end
        cyc();
        stray_ready = 1'b0;
        resp_en = 1'b1;

        // Watchdog on the TIMEOUT=8 instance
        t_i_read = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("to_gnt_rd", t_mem_read, 1'b1);
            chk("to_err_low", t_err, 1'b0);
        end
        @(negedge clk);
        chk("to_err_set", t_err, 1'b1);
        chk("to_idle_rd", t_mem_read, 1'b0);
        t_i_read = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("to_err_held", t_err, 1'b1);
            chk("to_no_ready", t_i_ready, 1'b0);
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("to_err_clr", t_err, 1'b0);

        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
